// File: rtl/axi_rd_rr_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel (AR + R) among NREQ requesters.
// One burst is granted at a time; the grant is held until the last R beat.
module axi_rd_rr_arbiter #(
  parameter  int NREQ = 4,
  parameter  int AW   = 32,
  parameter  int DW   = 32,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   s_arvalid,
  output logic [NREQ-1:0]   s_arready,
  input  logic [NREQ*AW-1:0] s_araddr,
  input  logic [NREQ*8-1:0] s_arlen,
  input  logic [NREQ*3-1:0] s_arsize,
  output logic [NREQ-1:0]   s_rvalid,
  input  logic [NREQ-1:0]   s_rready,
  output logic [DW-1:0]     s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [AW-1:0]     m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DW-1:0]     m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  output logic [IDW-1:0]    grant_id,
  output logic              busy,
  output logic              proto_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [IDW-1:0] r_grant_id;
  logic [IDW-1:0] r_last_grant;
  logic [7:0]     r_arlen;
  logic [7:0]     r_beat_cnt;
  logic           r_proto_err;
  logic [IDW-1:0] w_pick;
  logic [IDW-1:0] w_cand;
  logic           w_pick_vld;
  logic           w_ar_hs;
  logic           w_r_beat;

  // Scan from farthest to nearest offset so the nearest requester after last_grant wins.
  always_comb begin
    w_pick     = '0;
    w_pick_vld = 1'b0;
    w_cand     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_cand = IDW'((int'(r_last_grant) + k) % NREQ);
      if (s_arvalid[w_cand]) begin
        w_pick     = w_cand;
        w_pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    m_arvalid    = 1'b0;
    m_araddr     = '0;
    m_arlen      = '0;
    m_arsize     = '0;
    s_arready    = '0;
    s_rvalid     = '0;
    m_rready     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_pick_vld) w_state_next = S_ADDR;
      end
      S_ADDR: begin
        m_arvalid             = s_arvalid[r_grant_id];
        m_araddr              = s_araddr[int'(r_grant_id)*AW +: AW];
        m_arlen               = s_arlen[int'(r_grant_id)*8 +: 8];
        m_arsize              = s_arsize[int'(r_grant_id)*3 +: 3];
        s_arready[r_grant_id] = m_arready;
        if (s_arvalid[r_grant_id] && m_arready) w_state_next = S_DATA;
      end
      S_DATA: begin
        s_rvalid[r_grant_id] = m_rvalid;
        m_rready             = s_rready[r_grant_id];
        if (m_rvalid && s_rready[r_grant_id] && m_rlast) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_ar_hs  = (r_state == S_ADDR) && m_arvalid && m_arready;
  assign w_r_beat = (r_state == S_DATA) && m_rvalid && m_rready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= IDW'(NREQ - 1);
      r_grant_id   <= '0;
      r_arlen      <= '0;
      r_beat_cnt   <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            r_grant_id <= w_pick;
            r_arlen    <= s_arlen[int'(w_pick)*8 +: 8];
          end
        end
        S_ADDR: begin
          if (w_ar_hs) r_beat_cnt <= '0;
        end
        S_DATA: begin
          if (w_r_beat) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
            if (m_rlast) begin
              r_last_grant <= r_grant_id;
              if (r_beat_cnt != r_arlen) r_proto_err <= 1'b1;
            end else if (r_beat_cnt == r_arlen) begin
              // Expected last beat arrived without rlast; keep draining until it shows up.
              r_proto_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign m_arburst = 2'b01;
  assign s_rdata   = m_rdata;
  assign s_rresp   = m_rresp;
  assign s_rlast   = m_rlast;
  assign grant_id  = r_grant_id;
  assign busy      = (r_state != S_IDLE);
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_axi_rd_rr_arbiter.sv
// Scoreboard bench for axi_rd_rr_arbiter: stimulus queues expected AR/R transactions,
// a negedge monitor pops and compares them as the DUT presents handshakes.
module tb_axi_rd_rr_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
  logic [NREQ*AW-1:0] s_araddr;
  logic [NREQ*8-1:0]  s_arlen;
  logic [NREQ*3-1:0]  s_arsize;
  logic [DW-1:0]      s_rdata;
  logic [1:0]         s_rresp;
  logic               s_rlast;
  logic               m_arvalid, m_arready;
  logic [AW-1:0]      m_araddr;
  logic [7:0]         m_arlen;
  logic [2:0]         m_arsize;
  logic [1:0]         m_arburst;
  logic               m_rvalid, m_rready;
  logic [DW-1:0]      m_rdata;
  logic [1:0]         m_rresp;
  logic               m_rlast;
  logic [IDW-1:0]     grant_id;
  logic               busy, proto_err;

  always #5 clk = ~clk;

  axi_rd_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .grant_id(grant_id), .busy(busy), .proto_err(proto_err)
  );

  typedef struct { int req; logic [AW-1:0] addr; logic [7:0] len; } ar_exp_t;
  typedef struct { int req; logic [DW-1:0] data; logic last; } r_exp_t;
  typedef struct { string name; logic [31:0] act; logic [31:0] exp; } dir_t;

  ar_exp_t ar_q[$];
  r_exp_t  r_q[$];
  dir_t    d_q[$];
  int      n_err = 0;
  int      n_chk = 0;

  // Monitor: sole owner of the check counters.
  always @(negedge clk) begin : monitor
    ar_exp_t ea;
    r_exp_t  er;
    dir_t    d;
    logic [NREQ-1:0] exp_rdy;
    logic [NREQ-1:0] exp_rv;
    exp_rdy = '0;
    if (m_arvalid && m_arready && ar_q.size() > 0) exp_rdy = NREQ'(1) << ar_q[0].req;
    n_chk++;
    if (s_arready !== exp_rdy) begin
      n_err++;
      $display("FAIL arready_pulse act=%b exp=%b t=%0t", s_arready, exp_rdy, $time);
    end
    if (m_arvalid && m_arready) begin
      n_chk++;
      if (ar_q.size() == 0) begin
        n_err++;
        $display("FAIL ar_unexpected grant=%0d addr=%h t=%0t", grant_id, m_araddr, $time);
      end else begin
        ea = ar_q.pop_front();
        if (grant_id !== IDW'(ea.req) || m_araddr !== ea.addr || m_arlen !== ea.len ||
            m_arburst !== 2'b01) begin
          n_err++;
          $display("FAIL ar_txn act grant=%0d addr=%h len=%0d burst=%b exp grant=%0d addr=%h len=%0d burst=01",
                   grant_id, m_araddr, m_arlen, m_arburst, ea.req, ea.addr, ea.len);
        end else begin
          $display("AR  grant=%0d addr=%h len=%0d t=%0t", grant_id, m_araddr, m_arlen, $time);
        end
      end
    end
    if (|(s_rvalid & s_rready)) begin
      n_chk++;
      if (r_q.size() == 0) begin
        n_err++;
        $display("FAIL r_unexpected rvalid=%b data=%h t=%0t", s_rvalid, s_rdata, $time);
      end else begin
        er = r_q.pop_front();
        exp_rv = NREQ'(1) << er.req;
        if (s_rvalid !== exp_rv || s_rdata !== er.data || s_rlast !== er.last) begin
          n_err++;
          $display("FAIL r_beat act rvalid=%b data=%h last=%b exp rvalid=%b data=%h last=%b",
                   s_rvalid, s_rdata, s_rlast, exp_rv, er.data, er.last);
        end else begin
          $display("R   req=%0d data=%h last=%b t=%0t", er.req, s_rdata, s_rlast, $time);
        end
      end
    end else if (m_rvalid && r_q.size() > 0) begin
      n_chk++;
      n_err++;
      $display("FAIL beat_lost m_rvalid=1 s_rvalid=%b m_rready=%b exp_req=%0d t=%0t",
               s_rvalid, m_rready, r_q[0].req, $time);
    end
    while (d_q.size() > 0) begin
      d = d_q.pop_front();
      n_chk++;
      if (d.act !== d.exp) begin
        n_err++;
        $display("FAIL %s act=%0h exp=%0h", d.name, d.act, d.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    dir_t d;
    d.name = name;
    d.act  = act;
    d.exp  = exp;
    d_q.push_back(d);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    s_arvalid = '0;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rlast   = 1'b0;
    m_rdata   = '0;
    repeat (2) tick();
    expect_eq("rst_busy",      32'(busy),      32'd0);
    expect_eq("rst_grant_id",  32'(grant_id),  32'd0);
    expect_eq("rst_proto_err", 32'(proto_err), 32'd0);
    expect_eq("rst_m_arvalid", 32'(m_arvalid), 32'd0);
    expect_eq("rst_s_rvalid",  32'(s_rvalid),  32'd0);
    expect_eq("rst_m_rready",  32'(m_rready),  32'd0);
    expect_eq("rst_m_araddr",  32'(m_araddr),  32'd0);
    expect_eq("rst_m_arlen",   32'(m_arlen),   32'd0);
    rst = 1'b0;
  endtask

  // One burst for requester req: nbeats beats, rlast on beat last_at, AR stalled ar_stall
  // cycles, a two-cycle rvalid gap before beat gap_at, async reset instead of beat abort_at.
  task automatic serve(input int req, input int nbeats, input int last_at, input int ar_stall,
                       input int gap_at, input bit keep, input int abort_at);
    ar_exp_t ea;
    r_exp_t  er;
    int      n;
    ea.req  = req;
    ea.addr = s_araddr[req*AW +: AW];
    ea.len  = s_arlen[req*8 +: 8];
    ar_q.push_back(ea);
    n = 0;
    while (!m_arvalid && n < 20) begin
      tick();
      n++;
    end
    if (!m_arvalid) begin
      expect_eq("ar_timeout", 32'd1, 32'd0);
      return;
    end
    repeat (ar_stall) tick();
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    if (!keep) s_arvalid[req] = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      if (b == gap_at) begin
        m_rvalid = 1'b0;
        tick();
        tick();
      end
      if (b == abort_at) begin
        m_rvalid = 1'b1;
        m_rdata  = ea.addr + AW'(b);
        rst      = 1'b1;
        #1;
        expect_eq("abort_busy",      32'(busy),      32'd0);
        expect_eq("abort_s_rvalid",  32'(s_rvalid),  32'd0);
        expect_eq("abort_m_rready",  32'(m_rready),  32'd0);
        expect_eq("abort_grant_id",  32'(grant_id),  32'd0);
        expect_eq("abort_m_arvalid", 32'(m_arvalid), 32'd0);
        tick();
        m_rvalid = 1'b0;
        rst      = 1'b0;
        return;
      end
      er.req  = req;
      er.data = ea.addr + AW'(b);
      er.last = (b == last_at);
      r_q.push_back(er);
      m_rvalid = 1'b1;
      m_rdata  = er.data;
      m_rlast  = (b == last_at);
      tick();
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int order[5];
    order = '{0, 1, 2, 3, 0};
    s_rready  = '1;
    m_rresp   = 2'b00;
    s_arvalid = '0;
    for (int i = 0; i < NREQ; i++) begin
      s_araddr[i*AW +: AW] = 32'h1000 * (i + 1);
      s_arlen[i*8 +: 8]    = 8'd0;
      s_arsize[i*3 +: 3]   = 3'd2;
    end
    do_reset();

    // Single requester 0, arlen=3
    s_araddr[0 +: AW] = 32'h100;
    s_arlen[0 +: 8]   = 8'd3;
    s_arvalid[0]      = 1'b1;
    tick();
    expect_eq("t1_m_arvalid", 32'(m_arvalid), 32'd1);
    expect_eq("t1_m_araddr",  32'(m_araddr),  32'h100);
    expect_eq("t1_busy",      32'(busy),      32'd1);
    serve(0, 4, 3, 0, -1, 1'b0, -1);
    expect_eq("t1_busy_after", 32'(busy),      32'd0);
    expect_eq("t1_proto_err",  32'(proto_err), 32'd0);

    // All four requesting continuously, single-beat bursts
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      s_araddr[i*AW +: AW] = 32'h1000 * (i + 1);
      s_arlen[i*8 +: 8]    = 8'd0;
    end
    s_arvalid = '1;
    for (int i = 0; i < 5; i++) serve(order[i], 1, 0, 0, -1, 1'b1, -1);
    s_arvalid = '0;
    expect_eq("t2_proto_err", 32'(proto_err), 32'd0);

    // req2 burst, then req1+req3 together: req3 first
    s_arlen[2*8 +: 8] = 8'd1;
    s_arlen[1*8 +: 8] = 8'd1;
    s_arlen[3*8 +: 8] = 8'd1;
    s_arvalid[2] = 1'b1;
    serve(2, 2, 1, 0, -1, 1'b0, -1);
    s_arvalid[1] = 1'b1;
    s_arvalid[3] = 1'b1;
    serve(3, 2, 1, 0, -1, 1'b0, -1);
    serve(1, 2, 1, 0, -1, 1'b0, -1);

    // AR stall of 5 cycles and an rvalid gap mid-burst
    s_araddr[0 +: AW] = 32'h200;
    s_arlen[0 +: 8]   = 8'd3;
    s_arvalid[0]      = 1'b1;
    serve(0, 4, 3, 5, 2, 1'b0, -1);
    expect_eq("t4_proto_err", 32'(proto_err), 32'd0);

    // arlen=1 with rlast on beat 0
    s_arvalid[1] = 1'b1;
    serve(1, 1, 0, 0, -1, 1'b0, -1);
    expect_eq("t5a_proto_err", 32'(proto_err), 32'd1);
    expect_eq("t5a_busy",      32'(busy),      32'd0);
    do_reset();
    // arlen=3 with rlast on beat 2, then a clean burst: error stays sticky
    s_arlen[1*8 +: 8] = 8'd3;
    s_arvalid[1] = 1'b1;
    serve(1, 3, 2, 0, -1, 1'b0, -1);
    expect_eq("t5b_proto_err", 32'(proto_err), 32'd1);
    s_arlen[2*8 +: 8] = 8'd0;
    s_arvalid[2] = 1'b1;
    serve(2, 1, 0, 0, -1, 1'b0, -1);
    expect_eq("t5b_sticky", 32'(proto_err), 32'd1);
    do_reset();
    // arlen=1 but rlast only on beat 2: overrun flagged
    s_arlen[3*8 +: 8] = 8'd1;
    s_arvalid[3] = 1'b1;
    serve(3, 3, 2, 0, -1, 1'b0, -1);
    expect_eq("t5c_proto_err", 32'(proto_err), 32'd1);
    expect_eq("t5c_busy",      32'(busy),      32'd0);

    // Reset during beat 2 of an 8-beat burst; next grant restarts at requester 0
    do_reset();
    s_arlen[1*8 +: 8] = 8'd0;
    s_arvalid[1] = 1'b1;
    serve(1, 1, 0, 0, -1, 1'b0, -1);
    s_arlen[2*8 +: 8] = 8'd7;
    s_arvalid[2] = 1'b1;
    serve(2, 8, 7, 0, -1, 1'b0, 2);
    s_arlen[0 +: 8]   = 8'd0;
    s_arlen[2*8 +: 8] = 8'd0;
    s_arvalid[0] = 1'b1;
    s_arvalid[2] = 1'b1;
    serve(0, 1, 0, 0, -1, 1'b0, -1);
    serve(2, 1, 0, 0, -1, 1'b0, -1);
    expect_eq("t6_proto_err", 32'(proto_err), 32'd0);

    tick();
    expect_eq("end_ar_q_empty", 32'(ar_q.size()), 32'd0);
    expect_eq("end_r_q_empty",  32'(r_q.size()),  32'd0);
    repeat (2) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
